// File: rtl/spram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// spram_fifo_ctrl
//
// Purpose:
//   Turns a single-port SRAM (spram) into a synchronous FIFO with
//   valid/ready handshakes on both sides. At most one RAM operation is
//   issued per cycle, and a read takes priority over a write. One output
//   holding register absorbs the RAM's 1-cycle read latency and its
//   undefined dout while deselected. Total capacity is DP+1 words:
//   DP in the RAM plus one in the output register.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   producer has a word on in_data
//   in_ready   controller accepts in_data this cycle
//   in_data    write data
//   out_valid  out_data holds a valid word
//   out_ready  consumer takes out_data this cycle
//   out_data   head-of-FIFO word (registered)
//   count      words held: RAM + pending read + output register
//   ram_cs_n   spram chip select, active low
//   ram_w_r_n  spram direction, 1 = write, 0 = read
//   ram_addr   spram address
//   ram_din    spram write data
//   ram_dout   spram read data, valid the cycle after a read is issued
// ---------------------------------------------------------------------------
module spram_fifo_ctrl #(
   parameter int WD = 8,
   parameter int DP = 16,
   // DP is a power of two, so $clog2 equals floor(log2(DP)).
   parameter int AD = $clog2(DP)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [WD-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [WD-1:0] out_data,
   output logic [AD:0]   count,
   output logic          ram_cs_n,
   output logic          ram_w_r_n,
   output logic [AD-1:0] ram_addr,
   output logic [WD-1:0] ram_din,
   input  logic [WD-1:0] ram_dout
);

   localparam logic [AD:0] RAM_FULL  = (AD+1)'(DP);
   localparam logic [AD:0] RAM_EMPTY = {(AD+1){1'b0}};

   // Registered state
   logic [AD-1:0] wr_ptr_r;
   logic [AD-1:0] rd_ptr_r;
   logic [AD:0]   ram_cnt_r;
   logic          rd_pend_r;
   logic          out_valid_r;
   logic [WD-1:0] out_data_r;

   // Per-cycle decisions
   logic          do_rd_s;
   logic          do_wr_s;
   logic          in_ready_s;
   logic [AD:0]   count_s;

   // Read/write arbitration. A read is issued only when the output slot
   // will be free at the end of this cycle, and never while a previous read
   // is still in flight; that keeps rd_pend and out_valid mutually
   // exclusive and guarantees reads are never back-to-back, so writes
   // always get every other cycle at worst.
   always_comb begin
      do_rd_s    = 1'b0;
      in_ready_s = 1'b0;
      do_wr_s    = 1'b0;
      if (rst) begin
         do_rd_s    = 1'b0;
         in_ready_s = 1'b0;
         do_wr_s    = 1'b0;
      end else begin
         do_rd_s    = (ram_cnt_r != RAM_EMPTY) && !rd_pend_r &&
                      (!out_valid_r || out_ready);
         in_ready_s = (ram_cnt_r != RAM_FULL) && !do_rd_s;
         do_wr_s    = in_valid && in_ready_s;
      end
   end

   // RAM port drive: idle (cs_n high) unless a read or write is chosen.
   always_comb begin
      ram_cs_n  = !(do_rd_s || do_wr_s);
      ram_w_r_n = do_wr_s;
      ram_din   = in_data;
      if (do_wr_s) begin
         ram_addr = wr_ptr_r;
      end else begin
         ram_addr = rd_ptr_r;
      end
   end

   // Occupancy across RAM, the in-flight read and the output register.
   always_comb begin
      count_s = ram_cnt_r
              + {{AD{1'b0}}, rd_pend_r}
              + {{AD{1'b0}}, out_valid_r};
   end

   // Output drive; the reset cycle itself shows the cleared state even
   // before the first reset edge has loaded the registers.
   always_comb begin
      if (rst) begin
         in_ready  = 1'b0;
         out_valid = 1'b0;
         out_data  = {WD{1'b0}};
         count     = {(AD+1){1'b0}};
      end else begin
         in_ready  = in_ready_s;
         out_valid = out_valid_r;
         out_data  = out_data_r;
         count     = count_s;
      end
   end

   // Pointer and RAM occupancy update; pointers wrap DP-1 -> 0 naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r  <= {AD{1'b0}};
         rd_ptr_r  <= {AD{1'b0}};
         ram_cnt_r <= {(AD+1){1'b0}};
         rd_pend_r <= 1'b0;
      end else begin
         if (do_wr_s) begin
            wr_ptr_r <= wr_ptr_r + {{(AD-1){1'b0}}, 1'b1};
         end
         if (do_rd_s) begin
            rd_ptr_r <= rd_ptr_r + {{(AD-1){1'b0}}, 1'b1};
         end
         rd_pend_r <= do_rd_s;
         ram_cnt_r <= ram_cnt_r
                    + {{AD{1'b0}}, do_wr_s}
                    - {{AD{1'b0}}, do_rd_s};
      end
   end

   // Output register: capture the RAM word the cycle after a read; on a pop
   // with nothing arriving just drop valid and keep the old data.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_data_r  <= {WD{1'b0}};
      end else if (rd_pend_r) begin
         out_valid_r <= 1'b1;
         out_data_r  <= ram_dout;
      end else if (out_valid_r && out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

endmodule

// File: doc/spram_fifo_ctrl.md
Name: spram_fifo_ctrl

Overview:
Synchronous FIFO controller that drives the team's single-port SRAM (spram) and turns it into a FIFO with valid/ready ports on both sides. It sits between a producer and a consumer. It arbitrates one RAM operation per cycle between a write and a read, so it never relies on the RAM reading and writing in the same cycle. One output holding register absorbs the RAM's 1-cycle read latency and its X-on-deselect dout, giving a total capacity of DP+1 words.

Parameters:
WD, 8, data width; must match the spram WD.
DP, 16, RAM depth; a power of two, at least 2.
AD, clogb2(DP), address width (floor log2, the same function as spram).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  producer has a word.
in_ready  out  1  controller accepts the word this cycle.
in_data  in  WD  write data.
out_valid  out  1  out_data holds a valid word.
out_ready  in  1  consumer takes the word this cycle.
out_data  out  WD  head-of-FIFO word (registered).
count  out  AD+1  total words held (RAM + pending read + output register).
ram_cs_n  out  1  to spram cs_n; active low.
ram_w_r_n  out  1  to spram w_r_n; 1 = write, 0 = read.
ram_addr  out  AD  to spram addr.
ram_din  out  WD  to spram din.
ram_dout  in  WD  from spram dout; valid the cycle after a read is issued.

Behaviour:
- State: wr_ptr and rd_ptr (AD bits each; they wrap DP-1 -> 0 naturally), ram_cnt (0..DP), rd_pend, out_valid, out_data.
- Read decision (combinational): do_rd = !rst && ram_cnt!=0 && !rd_pend && (!out_valid || out_ready).
- Write side (combinational):
  - in_ready = !rst && ram_cnt!=DP && !do_rd.
  - do_wr = in_valid && in_ready.
  - Read has priority over write, so in_ready depends combinationally on out_ready.
- RAM drive (combinational):
  - ram_cs_n = !(do_rd || do_wr).
  - ram_w_r_n = do_wr.
  - ram_addr = do_wr ? wr_ptr : rd_ptr.
  - ram_din = in_data.
  - When neither do_rd nor do_wr is active, cs_n = 1 and the RAM is idle.
- Sequential updates on each edge:
  - do_wr: wr_ptr += 1.
  - do_rd: rd_ptr += 1; rd_pend <= 1. Otherwise rd_pend <= 0.
  - ram_cnt += do_wr - do_rd.
  - rd_pend = 1: out_data <= ram_dout, out_valid <= 1.
  - Else if out_valid && out_ready: out_valid <= 0, and out_data holds its value.
- Invariant: rd_pend and out_valid are never both 1. A read is issued only if the output slot is free by the end of that cycle.
- count = ram_cnt + rd_pend + out_valid, maximum DP+1.
- Latency: a word accepted at edge E (FIFO previously empty) is issued as a read in cycle E+1 and captured at edge E+2; out_valid is high in the cycle after E+2.
- Throughput:
  - The output delivers at most 1 word per 2 cycles, because of the read bubble.
  - A write can be accepted in any cycle without do_rd. Writes cannot starve: do_rd is never active in two consecutive cycles.
- Full: when ram_cnt==DP, in_ready=0. The output slot may still fill from the RAM, and the FIFO is full at count==DP+1.
- Empty: when ram_cnt==0 and no read is pending, out_valid falls after the last pop. There is no bypass path from in_data to out_data.
- Simultaneous push while the slot drains: do_rd wins and in_ready=0 for that cycle. The producer must hold in_valid and in_data until accepted.
- Reset state (also forced in the reset cycle):
  - Outputs: in_ready=0, out_valid=0, out_data=0, count=0, ram_cs_n=1.
  - Internal: pointers, ram_cnt and rd_pend cleared.
- Reset mid-operation: all contents are discarded. An in-flight read's ram_dout is ignored, and RAM contents are don't-care afterwards.
- out_data changes only on a capture, never while out_valid=1 && !out_ready.

Test Plan:
1. Hold rst high for 2 cycles, then release -> in_ready=0 during reset; afterwards in_ready=1, out_valid=0, count=0, ram_cs_n=1.
2. With out_ready=0, push 0xA1, 0xA2, 0xA3 back-to-back -> A1 written, then 1 cycle with in_ready=0 (read issued), then A2 and A3 written; out_data=0xA1, out_valid=1, count=3.
3. With out_ready=0, push 0x00..0x10 (17 words, DP=16) -> in_ready=0 once count=17. Then pop all with out_ready=1 -> out_data is 0x00..0x10 in order (pointer wrap exercised), count returns to 0 and out_valid falls.
4. Hold in_valid and out_ready both at 1 and stream 0x01..0x20 -> every word arrives once, in order; do_rd is never active on consecutive cycles; ram_cs_n never shows a read and a write in the same cycle.
5. Assert rst in the cycle after a read issue, with count=5 -> after reset count=0 and out_valid=0; the next push of 0x5A is the first word popped.
6. With out_valid=1, out_ready=1, ram_cnt=2 and in_valid=1 -> in_ready=0 that cycle, ram_w_r_n=0, ram_addr=rd_ptr; the write is accepted in the following cycle.
